// File: rtl/md_unit.sv
// Iterative 32-step multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit working register.
module md_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [2:0]  md_func,
  input  logic        md_sign,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        abort,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int CW = $clog2(ITER);

  localparam logic [2:0] F_MULT = 3'd1;
  localparam logic [2:0] F_DIV  = 3'd2;
  localparam logic [2:0] F_MTHI = 3'd3;
  localparam logic [2:0] F_MTLO = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [63:0]     work_q;
  logic [31:0]     opnd_q;
  logic            is_div_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            div0_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            done_q;

  logic            is_req_s;
  logic            is_rd_s;
  logic [32:0]     mul_sum_s;
  logic [33:0]     div_diff_s;
  logic [63:0]     work_d;
  logic [63:0]     prod_s;
  logic [31:0]     quot_s;
  logic [31:0]     rem_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? neg32(v) : v;
  endfunction

  assign is_req_s = valid && ((md_func == F_MULT) || (md_func == F_DIV) ||
                              (md_func == F_MTHI) || (md_func == F_MTLO));
  assign is_rd_s  = valid && (rd_hi || rd_lo);

  assign busy  = (state_q != S_IDLE);
  assign stall = busy && (is_req_s || is_rd_s);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

  // One iteration: multiply adds the multiplicand into the upper half then
  // shifts right; divide shifts left and keeps the trial subtraction if it fits.
  always_comb begin
    mul_sum_s  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_diff_s = {1'b0, work_q[63:31]} - {2'b00, opnd_q};
    work_d     = work_q;
    if (is_div_q) begin
      if (!div_diff_s[33]) begin
        work_d = {div_diff_s[31:0], work_q[30:0], 1'b1};
      end else begin
        work_d = {work_q[62:0], 1'b0};
      end
    end else begin
      work_d = {mul_sum_s, work_q[31:1]};
    end
  end

  // Sign correction of the finished magnitude result; a zero divisor keeps an
  // all-ones quotient and the remainder naturally reproduces op_a.
  always_comb begin
    prod_s = qneg_q ? neg64(work_q) : work_q;
    rem_s  = rneg_q ? neg32(work_q[63:32]) : work_q[63:32];
    if (div0_q) begin
      quot_s = 32'hFFFF_FFFF;
    end else begin
      quot_s = qneg_q ? neg32(work_q[31:0]) : work_q[31:0];
    end
  end

  // Control FSM plus datapath and architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid && !abort) begin
            case (md_func)
              F_MULT: begin
                opnd_q   <= mag32(op_a, md_sign);
                work_q   <= {32'd0, mag32(op_b, md_sign)};
                is_div_q <= 1'b0;
                qneg_q   <= md_sign & (op_a[31] ^ op_b[31]);
                rneg_q   <= md_sign & op_a[31];
                div0_q   <= 1'b0;
                cnt_q    <= '0;
                state_q  <= S_CALC;
              end
              F_DIV: begin
                opnd_q   <= mag32(op_b, md_sign);
                work_q   <= {32'd0, mag32(op_a, md_sign)};
                is_div_q <= 1'b1;
                qneg_q   <= md_sign & (op_a[31] ^ op_b[31]);
                rneg_q   <= md_sign & op_a[31];
                div0_q   <= (op_b == 32'd0);
                cnt_q    <= '0;
                state_q  <= S_CALC;
              end
              F_MTHI:  hi_q <= op_a;
              F_MTLO:  lo_q <= op_a;
              default: state_q <= S_IDLE;
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) begin
              state_q <= S_FIX;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!abort) begin
            if (is_div_q) begin
              hi_q <= rem_s;
              lo_q <= quot_s;
            end else begin
              hi_q <= prod_s[63:32];
              lo_q <= prod_s[31:0];
            end
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [2:0]  md_func;
  logic        md_sign;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        abort;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] F_NOP  = 3'd0;
  localparam logic [2:0] F_MULT = 3'd1;
  localparam logic [2:0] F_DIV  = 3'd2;
  localparam logic [2:0] F_MTHI = 3'd3;
  localparam logic [2:0] F_MTLO = 3'd4;

  md_unit #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .md_func(md_func),
    .md_sign(md_sign), .rd_hi(rd_hi), .rd_lo(rd_lo), .op_a(op_a),
    .op_b(op_b), .abort(abort), .hi(hi), .lo(lo), .busy(busy),
    .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  func;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic on the operand values.
  function automatic void ref_md(input logic [2:0] f, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rhi, output logic [31:0] rlo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    if (f == F_MULT) begin
      if (s) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
      end else begin
        up = {32'd0, a} * {32'd0, b};
      end
      rhi = up[63:32];
      rlo = up[31:0];
    end else if (b == 32'd0) begin
      rhi = a;
      rlo = 32'hFFFF_FFFF;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      rhi = 32'd0;
      rlo = 32'h8000_0000;
    end else if (s) begin
      sa  = $signed(a);
      sb  = $signed(b);
      rlo = sa / sb;
      rhi = sa % sb;
    end else begin
      rlo = a / b;
      rhi = a % b;
    end
  endfunction

  // Issue one op, then count busy cycles and done pulses until completion.
  task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int bcnt, output int dcnt);
    valid = 1'b1; md_func = f; md_sign = s; op_a = a; op_b = b;
    tick();
    valid = 1'b0; md_func = F_NOP;
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      bcnt++;
      if (done) dcnt++;
      tick();
    end
    if (done) dcnt++;
    tick();
    if (done) dcnt++;
  endtask

  vec_t        vecs[9];
  int          bc, dc, sc;
  logic [31:0] ehi, elo, save_hi, save_lo;
  logic [2:0]  rf;
  logic        rs;
  logic [31:0] ra, rb;

  initial begin
    vecs[0] = '{F_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{F_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{F_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{F_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{F_DIV,  1'b0, 32'd100,       32'd7,          32'd2,         32'd14};
    vecs[5] = '{F_DIV,  1'b0, 32'h1234_5678, 32'd0,          32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6] = '{F_DIV,  1'b1, 32'h8765_4321, 32'd0,          32'h8765_4321, 32'hFFFF_FFFF};
    vecs[7] = '{F_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[8] = '{F_DIV,  1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    rst_n = 1'b0; valid = 1'b0; md_func = F_NOP; md_sign = 1'b0;
    rd_hi = 1'b0; rd_lo = 1'b0; op_a = 32'd0; op_b = 32'd0; abort = 1'b0;
    #12;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].func, vecs[i].sgn, vecs[i].a, vecs[i].b, bc, dc);
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      check($sformatf("vec%0d_busycyc", i), 64'(bc), 64'd33);
      check($sformatf("vec%0d_donecnt", i), 64'(dc), 64'd1);
    end

    // MTHI/MTLO take one edge and are visible in the next cycle.
    valid = 1'b1; md_func = F_MTHI; op_a = 32'hAAAA_5555;
    tick();
    check("mthi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
    md_func = F_MTLO; op_a = 32'h1357_9BDF;
    tick();
    check("mtlo", {32'd0, lo}, {32'd0, 32'h1357_9BDF});
    valid = 1'b0; md_func = F_NOP;

    // HI read held from the cycle after MULT issue stalls until IDLE.
    valid = 1'b1; md_func = F_MULT; md_sign = 1'b1; op_a = 32'd3; op_b = 32'hFFFF_FFFC;
    tick();
    md_func = F_NOP; rd_hi = 1'b1;
    sc = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      sc++;
      tick();
    end
    check("rd_stall_cycles", 64'(sc), 64'd33);
    check("rd_new_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
    check("rd_new_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFF4});
    check("rd_done", {63'd0, done}, 64'd1);
    valid = 1'b0; rd_hi = 1'b0;
    tick();

    // MTLO held during busy applies only after the MULT commits.
    valid = 1'b1; md_func = F_MULT; md_sign = 1'b0; op_a = 32'd6; op_b = 32'd7;
    tick();
    md_func = F_MTLO; op_a = 32'hCAFE_F00D;
    check("mtlo_stalled", {63'd0, stall}, 64'd1);
    for (int i = 0; i < 40 && busy; i++) tick();
    check("mtlo_pre_lo", {32'd0, lo}, 64'd42);
    tick();
    valid = 1'b0; md_func = F_NOP;
    check("mtlo_after_lo", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});
    check("mtlo_after_hi", {32'd0, hi}, 64'd0);

    // Back-to-back: DIV held during MULT is accepted in the first IDLE cycle.
    valid = 1'b1; md_func = F_MULT; md_sign = 1'b0; op_a = 32'd9; op_b = 32'd11;
    tick();
    md_func = F_DIV; op_a = 32'd50; op_b = 32'd8;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("b2b_first_lo", {32'd0, lo}, 64'd99);
    check("b2b_idle_nostall", {63'd0, stall}, 64'd0);
    tick();
    valid = 1'b0; md_func = F_NOP;
    check("b2b_second_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 40 && busy; i++) tick();
    check("b2b_second_lo", {32'd0, lo}, 64'd6);
    check("b2b_second_hi", {32'd0, hi}, 64'd2);

    // Abort at CALC cycle 10: nothing committed, no done.
    save_hi = hi; save_lo = lo;
    valid = 1'b1; md_func = F_MULT; md_sign = 1'b0; op_a = 32'd1000; op_b = 32'd1000;
    tick();
    valid = 1'b0; md_func = F_NOP;
    for (int i = 0; i < 10; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      tick();
    end
    check("abort_nodone", 64'(dc), 64'd0);
    check("abort_hi", {32'd0, hi}, {32'd0, save_hi});
    check("abort_lo", {32'd0, lo}, {32'd0, save_lo});

    // Abort during FIX also discards the result.
    valid = 1'b1; md_func = F_MULT; op_a = 32'd77; op_b = 32'd77;
    tick();
    valid = 1'b0; md_func = F_NOP;
    for (int i = 0; i < 32; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abortfix_busy", {63'd0, busy}, 64'd0);
    check("abortfix_done", {63'd0, done}, 64'd0);
    check("abortfix_lo", {32'd0, lo}, {32'd0, save_lo});

    // Abort in IDLE blocks accepts, including MTHI.
    valid = 1'b1; abort = 1'b1; md_func = F_MULT;
    tick();
    check("abortidle_busy", {63'd0, busy}, 64'd0);
    md_func = F_MTHI; op_a = 32'hDEAD_BEEF;
    tick();
    check("abortidle_mthi", {32'd0, hi}, {32'd0, save_hi});
    valid = 1'b0; abort = 1'b0; md_func = F_NOP;

    run_op(F_MULT, 1'b1, 32'hFFFF_FFF0, 32'd16, bc, dc);
    check("post_abort_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
    check("post_abort_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FF00});

    // Async reset at CALC cycle 5 clears everything immediately.
    valid = 1'b1; md_func = F_DIV; md_sign = 1'b0; op_a = 32'd500; op_b = 32'd3;
    tick();
    valid = 1'b0; md_func = F_NOP;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run_op(F_MULT, 1'b0, 32'h0001_0000, 32'h0001_0000, bc, dc);
    check("post_rst_hi", {32'd0, hi}, 64'd1);
    check("post_rst_lo", {32'd0, lo}, 64'd0);
    check("post_rst_busycyc", 64'(bc), 64'd33);

    // Randomized MULT/DIV against the arithmetic reference.
    for (int n = 0; n < 200; n++) begin
      rf = ($urandom_range(0, 1) == 0) ? F_MULT : F_DIV;
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      ref_md(rf, rs, ra, rb, ehi, elo);
      run_op(rf, rs, ra, rb, bc, dc);
      check($sformatf("rnd%0d_hi f=%0d s=%0d a=%h b=%h", n, rf, rs, ra, rb), {32'd0, hi}, {32'd0, ehi});
      check($sformatf("rnd%0d_lo f=%0d s=%0d a=%h b=%h", n, rf, rs, ra, rb), {32'd0, lo}, {32'd0, elo});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
